rob_mc: RTL and testbench

- Parametrised multi-writeback, multi-commit reorder buffer. Successor to the single-commit ROB.
- Sits between dispatch, the CDB/functional-unit writeback ports, and the architectural regfile/RVFI commit logic.
- Allocates in-order tags and accepts out-of-order completions on NUM_WB ports.
- Retires up to COMMIT_W contiguous ready entries per cycle.
- Self-flushes when a mispredicted entry commits.

---
 rtl/rob_mc.sv | 174 +++++++++++++++++
 tb/tb_rob_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// Reorder buffer: in-order tag allocation, NUM_WB out-of-order writebacks, up to COMMIT_W in-order retires per cycle.
// Commit is combinational from registered state (a writeback retires one cycle later); dispatch stalls when full or flushing.
module rob_mc #(
    parameter int DEPTH     = 16,
    parameter int NUM_WB    = 4,
    parameter int COMMIT_W  = 2,
    parameter int PAYLOAD_W = 96,
    parameter int TAG_W     = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [4:0]                    disp_rd,
    input  logic                          disp_reg_write,
    input  logic [PAYLOAD_W-1:0]          disp_payload,
    output logic [TAG_W-1:0]              disp_tag,
    input  logic [NUM_WB-1:0]             wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]       wb_tag,
    input  logic [NUM_WB*32-1:0]          wb_value,
    input  logic [NUM_WB-1:0]             wb_mispredict,
    output logic [COMMIT_W-1:0]           commit_valid,
    output logic [COMMIT_W-1:0]           commit_we,
    output logic [COMMIT_W*5-1:0]         commit_rd,
    output logic [COMMIT_W*32-1:0]        commit_value,
    output logic [COMMIT_W*TAG_W-1:0]     commit_tag,
    output logic [COMMIT_W*PAYLOAD_W-1:0] commit_payload,
    output logic                          flush,
    output logic [TAG_W:0]                count
);

    localparam int PTR_W = TAG_W + 1;

    typedef struct packed {
        logic [4:0]           rd;
        logic                 reg_write;
        logic [31:0]          value;
        logic [PAYLOAD_W-1:0] payload;
    } ent_t;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d, misp_q, misp_d;
    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];

    logic             full;
    logic             disp_acc;
    logic [PTR_W-1:0] n_commit;
    logic             wb_dup;

    assign full       = (head_q[TAG_W-1:0] == tail_q[TAG_W-1:0]) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign disp_ready = !full && !flush;
    assign disp_tag   = tail_q[TAG_W-1:0];
    assign disp_acc   = disp_valid && disp_ready;
    assign count      = count_q;

    // Retire window: stops at the first non-ready entry and just after a mispredict.
    always_comb begin
        logic             chain;
        logic [TAG_W-1:0] idx;
        commit_valid   = '0;
        commit_we      = '0;
        commit_rd      = '0;
        commit_value   = '0;
        commit_tag     = '0;
        commit_payload = '0;
        flush          = 1'b0;
        n_commit       = '0;
        chain          = 1'b1;
        idx            = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            idx = head_q[TAG_W-1:0] + TAG_W'(k);
            if (chain && valid_q[idx] && ready_q[idx] && (PTR_W'(k) < count_q)) begin
                commit_valid[k]                          = 1'b1;
                commit_we[k]                             = ent_q[idx].reg_write;
                commit_rd[k*5 +: 5]                      = ent_q[idx].rd;
                commit_value[k*32 +: 32]                 = ent_q[idx].value;
                commit_tag[k*TAG_W +: TAG_W]             = idx;
                commit_payload[k*PAYLOAD_W +: PAYLOAD_W] = ent_q[idx].payload;
                n_commit                                 = n_commit + PTR_W'(1);
                if (misp_q[idx]) flush = 1'b1;
                chain = !misp_q[idx];
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_comb begin
        logic [TAG_W-1:0] t;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        ready_d = ready_q;
        misp_d  = misp_q;
        ent_d   = ent_q;
        t       = '0;
        // Ascending port order lets the highest port win on a tag collision.
        for (int i = 0; i < NUM_WB; i++) begin
            t = wb_tag[i*TAG_W +: TAG_W];
            if (wb_valid[i] && valid_q[t]) begin
                ent_d[t].value = wb_value[i*32 +: 32];
                ready_d[t]     = 1'b1;
                misp_d[t]      = wb_mispredict[i];
            end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            t = head_q[TAG_W-1:0] + TAG_W'(k);
            if (commit_valid[k]) begin
                valid_d[t] = 1'b0;
                ready_d[t] = 1'b0;
                misp_d[t]  = 1'b0;
            end
        end
        head_d = head_q + n_commit;
        if (disp_acc) begin
            t                  = tail_q[TAG_W-1:0];
            ent_d[t].rd        = disp_rd;
            ent_d[t].reg_write = disp_reg_write;
            ent_d[t].value     = '0;
            ent_d[t].payload   = disp_payload;
            valid_d[t]         = 1'b1;
            ready_d[t]         = 1'b0;
            misp_d[t]          = 1'b0;
            tail_d             = tail_q + PTR_W'(1);
        end
        count_d = count_q + PTR_W'(disp_acc) - n_commit;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            ready_d = '0;
            misp_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            ready_q <= '0;
            misp_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            misp_q  <= misp_d;
        end
    end

    // Entry data is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        wb_dup = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (wb_valid[i] && wb_valid[j] &&
                    (wb_tag[i*TAG_W +: TAG_W] == wb_tag[j*TAG_W +: TAG_W])) wb_dup = 1'b1;
            end
        end
    end

    wb_tag_unique_a: assert property (@(posedge clk) disable iff (!rst_n) !wb_dup);

endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc: dispatches push expected retires, a negedge monitor pops and compares them.
module tb_rob_mc;
    localparam int DEPTH = 16;
    localparam int NWB   = 4;
    localparam int CW    = 2;
    localparam int PW    = 96;
    localparam int TW    = 4;

    typedef struct {
        logic [TW-1:0] tag;
        logic [4:0]    rd;
        logic          we;
        logic [PW-1:0] pl;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_valid;
    logic              disp_ready;
    logic [4:0]        disp_rd;
    logic              disp_reg_write;
    logic [PW-1:0]     disp_payload;
    logic [TW-1:0]     disp_tag;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*TW-1:0] wb_tag;
    logic [NWB*32-1:0] wb_value;
    logic [NWB-1:0]    wb_mispredict;
    logic [CW-1:0]     commit_valid;
    logic [CW-1:0]     commit_we;
    logic [CW*5-1:0]   commit_rd;
    logic [CW*32-1:0]  commit_value;
    logic [CW*TW-1:0]  commit_tag;
    logic [CW*PW-1:0]  commit_payload;
    logic              flush;
    logic [TW:0]       count;

    rob_mc #(.DEPTH(DEPTH), .NUM_WB(NWB), .COMMIT_W(CW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_reg_write(disp_reg_write), .disp_payload(disp_payload), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_tag(commit_tag), .commit_payload(commit_payload),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_ret = 0;
    int            n_exp = 0;
    exp_t          sb_q[$];
    logic [TW-1:0] wb_pend[$];
    logic [31:0]   val_by_tag [DEPTH];
    logic          misp_by_tag [DEPTH];
    logic [TW-1:0] tail_exp;

    task automatic chk(input string tg, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tg, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_drive(input int p, input logic [TW-1:0] t, input logic m);
        logic [31:0] v;
        v = $urandom;
        wb_valid[p]          = 1'b1;
        wb_tag[p*TW +: TW]   = t;
        wb_value[p*32 +: 32] = v;
        wb_mispredict[p]     = m;
        val_by_tag[t]        = v;
        misp_by_tag[t]       = m;
    endtask

    int rot = 0;
    // One cycle: optionally dispatch, and write back up to nwb of the oldest pending tags.
    task automatic cyc(input bit d, input int nwb, input logic [4:0] rd);
        exp_t e;
        wb_valid = '0;
        for (int p = 0; p < nwb && wb_pend.size() > 0; p++) begin
            wb_drive((p + rot) % NWB, wb_pend.pop_front(), 1'b0);
        end
        rot++;
        if (d) begin
            disp_valid     = 1'b1;
            disp_rd        = rd;
            disp_reg_write = 1'($urandom);
            disp_payload   = {$urandom, $urandom, $urandom};
            if (disp_ready) begin
                chk("disp_tag", disp_tag, tail_exp);
                e.tag = tail_exp; e.rd = rd; e.we = disp_reg_write; e.pl = disp_payload;
                sb_q.push_back(e);
                wb_pend.push_back(tail_exp);
                tail_exp++;
                n_exp++;
            end
        end
        step();
        disp_valid = 1'b0;
        wb_valid   = '0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb_q.size() > 0 && b < 200) begin
            cyc(1'b0, NWB, 5'd0);
            b++;
        end
        chk("drain_left", sb_q.size(), 0);
        chk("drain_count", count, 0);
    endtask

    // Retire monitor: commit outputs depend on registered state only, so negedge is stable.
    always @(negedge clk) begin
        bit   brk;
        bit   ef;
        exp_t e;
        if (rst_n === 1'b1) begin
            brk = 1'b0;
            ef  = 1'b0;
            for (int k = 0; k < CW; k++) begin
                chk("contig", commit_valid[k] & (brk | ef), 0);
                if (commit_valid[k]) begin
                    if (sb_q.size() == 0) begin
                        chk("unexp_commit", commit_valid[k], 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("c_tag", commit_tag[k*TW +: TW], e.tag);
                        chk("c_rd", commit_rd[k*5 +: 5], e.rd);
                        chk("c_we", commit_we[k], e.we);
                        chk("c_val", commit_value[k*32 +: 32], val_by_tag[e.tag]);
                        chk("c_pl", commit_payload[k*PW +: PW], e.pl);
                        n_ret++;
                        if (misp_by_tag[e.tag]) ef = 1'b1;
                    end
                end else begin
                    brk = 1'b1;
                end
            end
            chk("flush", flush, ef);
            if (ef) begin
                n_exp -= sb_q.size();
                sb_q.delete();
                wb_pend.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] t0;
        rst_n = 1'b0; disp_valid = 1'b0; disp_rd = '0; disp_reg_write = 1'b0; disp_payload = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_mispredict = '0;
        tail_exp = '0;
        for (int i = 0; i < DEPTH; i++) begin val_by_tag[i] = '0; misp_by_tag[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cv", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_rdy", disp_ready, 1);
        chk("rst_tag", disp_tag, 0);
        chk("rst_cnt", count, 0);
        #3 rst_n = 1'b1;
        step();

        // Out-of-order writeback, in-order retire two then one.
        cyc(1'b1, 0, 5'd1); cyc(1'b1, 0, 5'd2); cyc(1'b1, 0, 5'd3);
        chk("t1_cnt3", count, 3);
        wb_pend.delete();
        wb_drive(0, 4'd2, 1'b0); wb_drive(1, 4'd0, 1'b0); wb_drive(2, 4'd1, 1'b0);
        step();
        wb_valid = '0;
        chk("t1_cv11", commit_valid, 2'b11);
        chk("t1_cnt_a", count, 3);
        step();
        chk("t1_cv01", commit_valid, 2'b01);
        chk("t1_cnt_b", count, 1);
        step();
        chk("t1_cv00", commit_valid, 2'b00);
        chk("t1_cnt_c", count, 0);

        // Fill to full; a commit in the full cycle must not let a dispatch through.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 0, 5'($urandom));
        chk("t2_cnt16", count, 16);
        chk("t2_rdy0", disp_ready, 0);
        cyc(1'b0, 2, 5'd0);
        chk("t2_cv11", commit_valid, 2'b11);
        disp_valid = 1'b1;
        chk("t2_rdy_full", disp_ready, 0);
        step();
        disp_valid = 1'b0;
        chk("t2_cnt14", count, 14);
        chk("t2_rdy1", disp_ready, 1);
        drain();

        // Steady stream across several pointer wraps.
        for (int i = 0; i < 40; i++) cyc(1'b1, 1, 5'($urandom));
        drain();

        // Mispredict in the middle: commits with flush, younger entry discarded.
        cyc(1'b1, 0, 5'd4); cyc(1'b1, 0, 5'd5); cyc(1'b1, 0, 5'd6);
        wb_pend.delete();
        t0 = tail_exp - 4'd3;
        wb_drive(0, t0, 1'b0); wb_drive(1, t0 + 4'd1, 1'b1); wb_drive(2, t0 + 4'd2, 1'b0);
        step();
        wb_valid = '0;
        chk("t4_cv11", commit_valid, 2'b11);
        chk("t4_flush", flush, 1);
        chk("t4_rdy0", disp_ready, 0);
        disp_valid = 1'b1;
        step();
        disp_valid = 1'b0;
        tail_exp = '0;
        chk("t4_cnt0", count, 0);
        chk("t4_tag0", disp_tag, 0);
        chk("t4_rdy1", disp_ready, 1);
        chk("t4_cv00", commit_valid, 0);
        chk("t4_sb", sb_q.size(), 0);

        // Stray writeback to a free tag; a hole at tag 1 stops retire at slot 0.
        cyc(1'b1, 0, 5'd7); cyc(1'b1, 0, 5'd8); cyc(1'b1, 0, 5'd9);
        wb_pend.delete();
        wb_valid[0] = 1'b1; wb_tag[0 +: TW] = 4'd7; wb_value[0 +: 32] = 32'hDEAD_BEEF; wb_mispredict[0] = 1'b1;
        step();
        wb_valid = '0;
        chk("t5_cnt3", count, 3);
        chk("t5_cv_none", commit_valid, 0);
        wb_drive(0, 4'd0, 1'b0); wb_drive(1, 4'd2, 1'b0);
        step();
        wb_valid = '0;
        chk("t5_cv01", commit_valid, 2'b01);
        step();
        chk("t5_cv_hole", commit_valid, 0);
        chk("t5_cnt2", count, 2);
        wb_pend.push_back(4'd1);
        drain();

        // Asynchronous reset with live entries.
        for (int i = 0; i < 5; i++) cyc(1'b1, 0, 5'($urandom));
        chk("t6_cnt5", count, 5);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_cnt", count, 0);
        chk("t6_tag", disp_tag, 0);
        chk("t6_rdy", disp_ready, 1);
        chk("t6_cv", commit_valid, 0);
        chk("t6_flush", flush, 0);
        n_exp -= sb_q.size();
        sb_q.delete();
        wb_pend.delete();
        tail_exp = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("t6_rdy_rel", disp_ready, 1);
        chk("t6_cnt_rel", count, 0);
        cyc(1'b1, 0, 5'd10); cyc(1'b1, 0, 5'd11);
        drain();

        chk("retired", n_ret, n_exp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
